// File: rtl/text_grid_pkg.sv
// Shared types and glyph constants for the text grid renderer.
package text_grid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned GLYPH_DIM  = 8;
  localparam int unsigned GLYPH_BITS = GLYPH_DIM * GLYPH_DIM;

  localparam logic [7:0] GLYPH_R     = 8'd16;
  localparam logic [7:0] GLYPH_COLON = 8'd17;
  localparam logic [7:0] GLYPH_BLANK = 8'd18;

  // Packs eight glyph rows, given top to bottom, so row r lands at [8r+7:8r].
  function automatic logic [GLYPH_BITS-1:0] glyph_rows(
    input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3,
    input logic [7:0] r4, input logic [7:0] r5, input logic [7:0] r6, input logic [7:0] r7
  );
    return {r7, r6, r5, r4, r3, r2, r1, r0};
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// 8x8 character generator: hex digits, 'R' and ':'; every other code is blank.
module glyph_rom
  import text_grid_pkg::*;
(
  input  logic [7:0]            code,
  output logic [GLYPH_BITS-1:0] glyph
);

  always_comb begin
    glyph = '0;
    case (code)
      8'd0:        glyph = glyph_rows(8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00);
      8'd1:        glyph = glyph_rows(8'h10, 8'h70, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00);
      8'd2:        glyph = glyph_rows(8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00);
      8'd3:        glyph = glyph_rows(8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00);
      8'd4:        glyph = glyph_rows(8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00);
      8'd5:        glyph = glyph_rows(8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00);
      8'd6:        glyph = glyph_rows(8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00);
      8'd7:        glyph = glyph_rows(8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00);
      8'd8:        glyph = glyph_rows(8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00);
      8'd9:        glyph = glyph_rows(8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00);
      8'd10:       glyph = glyph_rows(8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00);
      8'd11:       glyph = glyph_rows(8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00);
      8'd12:       glyph = glyph_rows(8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00);
      8'd13:       glyph = glyph_rows(8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00);
      8'd14:       glyph = glyph_rows(8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00);
      8'd15:       glyph = glyph_rows(8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h60, 8'h00);
      GLYPH_R:     glyph = glyph_rows(8'h7C, 8'h66, 8'h66, 8'h7C, 8'h6C, 8'h66, 8'h66, 8'h00);
      GLYPH_COLON: glyph = glyph_rows(8'h00, 8'h18, 8'h18, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00);
      default:     glyph = '0;
    endcase
  end

endmodule

// File: rtl/text_grid_renderer.sv
// Walks a NUM_ROWS x NUM_COLS character grid and emits one VGA pixel write per cycle.
module text_grid_renderer
  import text_grid_pkg::*;
#(
  parameter int unsigned NUM_ROWS  = 8,
  parameter int unsigned NUM_COLS  = 4,
  parameter int unsigned X0        = 10,
  parameter int unsigned Y0        = 10,
  parameter int unsigned COL_PITCH = 9,
  parameter int unsigned ROW_PITCH = 15,
  parameter logic [2:0]  FG        = 3'b111,
  parameter logic [2:0]  BG        = 3'b000,
  parameter int unsigned COORD_W   = 10,
  localparam int unsigned ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int unsigned COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               continuous,
  input  logic               transparent,
  output logic [ROW_W-1:0]   char_row,
  output logic [COL_W-1:0]   char_col,
  input  logic [7:0]         char_code,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [2:0]         color,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PIX_W = $clog2(GLYPH_DIM);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(GLYPH_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

  if (NUM_ROWS < 1) begin : g_bad_rows
    $error("NUM_ROWS must be at least 1");
  end
  if (NUM_COLS < 1) begin : g_bad_cols
    $error("NUM_COLS must be at least 1");
  end
  if (COL_PITCH < GLYPH_DIM) begin : g_bad_col_pitch
    $error("COL_PITCH must be at least 8");
  end
  if (ROW_PITCH < GLYPH_DIM) begin : g_bad_row_pitch
    $error("ROW_PITCH must be at least 8");
  end

  state_t           state, state_n;
  logic [ROW_W-1:0] row, row_n;
  logic [COL_W-1:0] col, col_n;
  logic [PIX_W-1:0] px, px_n;
  logic [PIX_W-1:0] py, py_n;
  logic [7:0]       code, code_n;
  logic [GLYPH_BITS-1:0] glyph;
  logic             pixel;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      px    <= '0;
      py    <= '0;
      code  <= '0;
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
      px    <= px_n;
      py    <= py_n;
      code  <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    px_n    = px;
    py_n    = py;
    code_n  = code;
    case (state)
      IDLE: begin
        if (start) begin
          row_n   = '0;
          col_n   = '0;
          px_n    = '0;
          py_n    = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        code_n  = char_code;
        state_n = DRAW;
      end
      DRAW: begin
        px_n = px + 1'b1;
        if (px == PIX_LAST) begin
          py_n = py + 1'b1;
          // Last pixel of the glyph: advance to the next character in raster order.
          if (py == PIX_LAST) begin
            if (col != COL_LAST) begin
              col_n   = col + 1'b1;
              state_n = FETCH;
            end else if (row != ROW_LAST) begin
              col_n   = '0;
              row_n   = row + 1'b1;
              state_n = FETCH;
            end else begin
              state_n = DONE;
            end
          end
        end
      end
      DONE: begin
        if (start || continuous) begin
          row_n   = '0;
          col_n   = '0;
          px_n    = '0;
          py_n    = '0;
          state_n = FETCH;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  glyph_rom u_glyph_rom (
    .code  (code),
    .glyph (glyph)
  );

  // Bit (7-px) of glyph row py; ~px is 7-px for a 3-bit index.
  assign pixel = glyph[{py, ~px}];

  assign char_row = row;
  assign char_col = col;
  assign x     = COORD_W'(X0) + COORD_W'(col) * COORD_W'(COL_PITCH) + COORD_W'(px);
  assign y     = COORD_W'(Y0) + COORD_W'(row) * COORD_W'(ROW_PITCH) + COORD_W'(py);
  assign color = ((state == DRAW) && pixel) ? FG : BG;
  assign plot  = (state == DRAW) && (!transparent || pixel);
  assign busy  = (state == FETCH) || (state == DRAW);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_text_grid_renderer.sv
// Directed bench for text_grid_renderer: default grid plus a 2x3 grid at X0=600.
module tb_text_grid_renderer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn;
  logic       start_a, continuous_a, transparent_a;
  logic [7:0] code_a;
  logic [2:0] row_a;
  logic [1:0] col_a;
  logic [9:0] x_a, y_a;
  logic [2:0] color_a;
  logic       plot_a, busy_a, done_a;

  logic       start_b, continuous_b, transparent_b;
  logic [7:0] code_b;
  logic [0:0] row_b;
  logic [1:0] col_b;
  logic [9:0] x_b, y_b;
  logic [2:0] color_b;
  logic       plot_b, busy_b, done_b;

  int mem_mode;
  int tests = 0;
  int fails = 0;

  text_grid_renderer dut_a (
    .clock(clock), .resetn(resetn), .start(start_a), .continuous(continuous_a),
    .transparent(transparent_a), .char_row(row_a), .char_col(col_a), .char_code(code_a),
    .x(x_a), .y(y_a), .color(color_a), .plot(plot_a), .busy(busy_a), .done(done_a)
  );

  text_grid_renderer #(
    .NUM_ROWS(2), .NUM_COLS(3), .X0(600), .COL_PITCH(20)
  ) dut_b (
    .clock(clock), .resetn(resetn), .start(start_b), .continuous(continuous_b),
    .transparent(transparent_b), .char_row(row_b), .char_col(col_b), .char_code(code_b),
    .x(x_b), .y(y_b), .color(color_b), .plot(plot_b), .busy(busy_b), .done(done_b)
  );

  // Character memory model: mode 0 is all blank, mode 1 places '1', 'R' and ':'.
  function automatic logic [7:0] mem_code(input int r, input int c, input int mode);
    if (mode == 0) return 8'd18;
    if (r == 0 && c == 0) return 8'd1;
    if (r == 0 && c == 1) return 8'd16;
    if (r == 1 && c == 0) return 8'd17;
    return 8'd18;
  endfunction

  always_comb code_a = mem_code(int'(row_a), int'(col_a), mem_mode);
  assign code_b = 8'd18;

  typedef struct {
    bit tr;
    int k;
    int p;
    int ex;
    int ey;
    int ecolor;
    int eplot;
    int erow;
    int ecol;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Character k (raster index), pixel p (8*py+px) is on the outputs after 2+65k+p edges.
  task automatic apply_vec(input int idx, input vec_t v);
    int n;
    n = 2 + 65 * v.k + v.p;
    do_reset();
    mem_mode      = 1;
    transparent_a = v.tr;
    start_a       = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    repeat (n - 1) @(negedge clock);
    check($sformatf("v%0d_x", idx), int'(x_a), v.ex);
    check($sformatf("v%0d_y", idx), int'(y_a), v.ey);
    check($sformatf("v%0d_color", idx), int'(color_a), v.ecolor);
    check($sformatf("v%0d_plot", idx), int'(plot_a), v.eplot);
    check($sformatf("v%0d_busy", idx), int'(busy_a), 1);
    check($sformatf("v%0d_row", idx), int'(row_a), v.erow);
    check($sformatf("v%0d_col", idx), int'(col_a), v.ecol);
  endtask

  // Starts a pass and samples until the done pulse or the cycle budget runs out.
  task automatic run_pass(input bit sel, input int limit, input int restart_at, input int probe_at,
                          output int nbusy, output int nplot, output int nplot00,
                          output int nbg, output int probe_x, output bit got_done);
    nbusy = 0; nplot = 0; nplot00 = 0; nbg = 0; probe_x = -1; got_done = 1'b0;
    set_start(sel, 1'b1);
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      set_start(sel, (i == restart_at) ? 1'b1 : 1'b0);
      if (sel ? busy_b : busy_a) nbusy++;
      if (sel ? plot_b : plot_a) begin
        nplot++;
        if ((sel ? int'(row_b) : int'(row_a)) == 0 && (sel ? int'(col_b) : int'(col_a)) == 0)
          nplot00++;
        if ((sel ? color_b : color_a) == 3'b000) nbg++;
      end
      if (i == probe_at) probe_x = sel ? int'(x_b) : int'(x_a);
      if (sel ? done_b : done_a) begin
        got_done = 1'b1;
        break;
      end
    end
    set_start(sel, 1'b0);
  endtask

  initial begin
    int nbusy, nplot, nplot00, nbg, probe_x, per, ndone;
    bit got_done;

    vecs[0]  = '{0, 0,  9, 11,  11, 7, 1, 0, 0};
    vecs[1]  = '{0, 0,  8, 10,  11, 0, 1, 0, 0};
    vecs[2]  = '{1, 0,  8, 10,  11, 0, 0, 0, 0};
    vecs[3]  = '{1, 0,  9, 11,  11, 7, 1, 0, 0};
    vecs[4]  = '{0, 0,  3, 13,  10, 7, 1, 0, 0};
    vecs[5]  = '{0, 1,  0, 19,  10, 0, 1, 0, 1};
    vecs[6]  = '{1, 1,  1, 20,  10, 7, 1, 0, 1};
    vecs[7]  = '{1, 1, 63, 26,  17, 0, 0, 0, 1};
    vecs[8]  = '{0, 4, 11, 13,  26, 7, 1, 1, 0};
    vecs[9]  = '{1, 4, 10, 12,  26, 0, 0, 1, 0};
    vecs[10] = '{0, 31, 63, 44, 122, 0, 1, 7, 3};
    vecs[11] = '{1, 4, 12, 14,  26, 7, 1, 1, 0};

    resetn = 1'b0;
    start_a = 1'b0; continuous_a = 1'b0; transparent_a = 1'b0;
    start_b = 1'b0; continuous_b = 1'b0; transparent_b = 1'b0;
    mem_mode = 0;
    #12;
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_plot", int'(plot_a), 0);
    check("rst_x", int'(x_a), 10);
    check("rst_y", int'(y_a), 10);
    check("rst_color", int'(color_a), 0);
    check("rst_x_b", int'(x_b), 600);
    @(negedge clock);
    resetn = 1'b1;

    // Blank grid, single start.
    run_pass(1'b0, 3000, -1, -1, nbusy, nplot, nplot00, nbg, probe_x, got_done);
    check("blank_done", int'(got_done), 1);
    check("blank_busy_cycles", nbusy, 2080);
    check("blank_plots", nplot, 2048);
    check("blank_bg_plots", nbg, 2048);
    check("blank_done_busy", int'(busy_a), 0);
    @(negedge clock);
    check("blank_done_width", int'(done_a), 0);
    repeat (5) @(negedge clock);
    check("blank_idle_busy", int'(busy_a), 0);

    for (int i = 0; i < 12; i++) apply_vec(i, vecs[i]);

    // Transparent pass: only set pixels plot; timing unchanged.
    do_reset();
    mem_mode = 1;
    transparent_a = 1'b1;
    run_pass(1'b0, 3000, -1, -1, nbusy, nplot, nplot00, nbg, probe_x, got_done);
    check("transp_done", int'(got_done), 1);
    check("transp_busy_cycles", nbusy, 2080);
    check("transp_plots_00", nplot00, 9);
    check("transp_bg_plots", nbg, 0);
    transparent_a = 1'b0;

    // Continuous mode: DONE goes straight back to FETCH at (0,0).
    do_reset();
    mem_mode = 0;
    continuous_a = 1'b1;
    run_pass(1'b0, 3000, -1, -1, nbusy, nplot, nplot00, nbg, probe_x, got_done);
    check("cont_first_done", int'(got_done), 1);
    per = 0;
    got_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      per++;
      if (i == 0) begin
        check("cont_fetch_busy", int'(busy_a), 1);
        check("cont_fetch_plot", int'(plot_a), 0);
        check("cont_fetch_row", int'(row_a), 0);
        check("cont_fetch_col", int'(col_a), 0);
      end
      if (done_a) begin
        got_done = 1'b1;
        break;
      end
    end
    check("cont_second_done", int'(got_done), 1);
    check("cont_period", per, 2081);
    continuous_a = 1'b0;
    @(negedge clock);
    check("cont_stop_busy", int'(busy_a), 0);
    check("cont_stop_done", int'(done_a), 0);

    // Reset mid-pass aborts without a done pulse.
    do_reset();
    mem_mode = 0;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    repeat (999) @(negedge clock);
    check("mid_busy_before", int'(busy_a), 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_done", int'(done_a), 0);
    check("mid_rst_plot", int'(plot_a), 0);
    check("mid_rst_x", int'(x_a), 10);
    check("mid_rst_y", int'(y_a), 10);
    check("mid_rst_color", int'(color_a), 0);
    check("mid_rst_row", int'(row_a), 0);
    check("mid_rst_col", int'(col_a), 0);
    @(negedge clock);
    resetn = 1'b1;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done_a) ndone++;
      if (busy_a) nbusy++;
    end
    check("mid_no_done", ndone, 0);
    check("mid_idle_wait", nbusy, 0);
    run_pass(1'b0, 3000, -1, -1, nbusy, nplot, nplot00, nbg, probe_x, got_done);
    check("mid_restart_done", int'(got_done), 1);
    check("mid_restart_busy", nbusy, 2080);

    // 2x3 grid at X0=600; a start while busy is ignored.
    do_reset();
    run_pass(1'b1, 1000, 100, 138, nbusy, nplot, nplot00, nbg, probe_x, got_done);
    check("small_done", int'(got_done), 1);
    check("small_busy_cycles", nbusy, 390);
    check("small_plots", nplot, 384);
    check("small_x_col2_px7", probe_x, 647);
    @(negedge clock);
    check("small_idle_busy", int'(busy_b), 0);
    check("small_done_width", int'(done_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
